// File: rtl/dot_box_pkg.sv
// Shared types and constant helpers for the dot_box_param dot-product engine.
package dot_box_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Accumulator is wide enough that VEC_LEN full-scale products never overflow.
    function automatic int acc_width(input int data_w, input int vec_len);
        return 2 * data_w + $clog2(vec_len);
    endfunction

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/dot_box_sat_round.sv
// Combinational clamp of the accumulator to OUT_W bits, then shift/round/clamp to OUT16_W bits.
// Saturation flag ports exist only when DOT_BOX_SAT_FLAG_EN is defined.
module dot_box_sat_round
    import dot_box_pkg::*;
#(
    parameter int ACC_W      = 36,
    parameter int OUT_W      = 32,
    parameter int FRAC_SHIFT = 16,
    parameter int OUT16_W    = 16
) (
    input  logic signed [ACC_W-1:0]   acc,
    output logic signed [OUT_W-1:0]   clip,
    output logic signed [OUT16_W-1:0] dat16
`ifdef DOT_BOX_SAT_FLAG_EN
    ,
    output logic                      sat_full,
    output logic                      sat16
`endif
);
    localparam int EXT_W   = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam int S_W     = OUT_W + 1;
    localparam int EXT16_W = ((S_W > OUT16_W) ? S_W : OUT16_W) + 1;

    localparam logic signed [EXT_W-1:0]   FULL_MAX = EXT_W'(sat_max(OUT_W));
    localparam logic signed [EXT_W-1:0]   FULL_MIN = EXT_W'(sat_min(OUT_W));
    localparam logic signed [EXT16_W-1:0] D16_MAX  = EXT16_W'(sat_max(OUT16_W));
    localparam logic signed [EXT16_W-1:0] D16_MIN  = EXT16_W'(sat_min(OUT16_W));

    logic signed [EXT_W-1:0]   acc_ext_s;
    logic signed [S_W-1:0]     clip_ext_s;
    logic signed [S_W-1:0]     round_s;
    logic signed [EXT16_W-1:0] round_ext_s;
    logic                      full_hi_s;
    logic                      full_lo_s;
    logic                      d16_hi_s;
    logic                      d16_lo_s;

    assign acc_ext_s = {{(EXT_W - ACC_W){acc[ACC_W-1]}}, acc};

    // Clamp the accumulator into the OUT_W result range.
    always_comb begin
        full_hi_s = (acc_ext_s > FULL_MAX);
        full_lo_s = (acc_ext_s < FULL_MIN);
        if (full_hi_s) begin
            clip = FULL_MAX[OUT_W-1:0];
        end else if (full_lo_s) begin
            clip = FULL_MIN[OUT_W-1:0];
        end else begin
            clip = acc_ext_s[OUT_W-1:0];
        end
    end

    // One spare bit keeps a rounded-up positive maximum from wrapping negative.
    assign clip_ext_s  = {clip[OUT_W-1], clip};
    assign round_s     = (clip_ext_s >>> FRAC_SHIFT)
                       + $signed({{OUT_W{1'b0}}, clip[FRAC_SHIFT-1]});
    assign round_ext_s = {{(EXT16_W - S_W){round_s[S_W-1]}}, round_s};

    // Clamp the rounded value into the OUT16_W range.
    always_comb begin
        d16_hi_s = (round_ext_s > D16_MAX);
        d16_lo_s = (round_ext_s < D16_MIN);
        if (d16_hi_s) begin
            dat16 = D16_MAX[OUT16_W-1:0];
        end else if (d16_lo_s) begin
            dat16 = D16_MIN[OUT16_W-1:0];
        end else begin
            dat16 = round_ext_s[OUT16_W-1:0];
        end
    end

`ifdef DOT_BOX_SAT_FLAG_EN
    assign sat_full = full_hi_s | full_lo_s;
    assign sat16    = d16_hi_s | d16_lo_s;
`endif

endmodule

// File: rtl/dot_box_param.sv
// dot_box_param: one-MAC-per-cycle signed dot product with saturated full and shifted/rounded outputs.
// Defining DOT_BOX_SAT_FLAG_EN adds the registered OUT_SAT saturation flag.
module dot_box_param
    import dot_box_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int VEC_LEN    = 8,
    parameter int OUT_W      = 32,
    parameter int FRAC_SHIFT = 16,
    parameter int OUT16_W    = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [VEC_LEN-1:0][DATA_W-1:0] IN_X,
    input  logic [VEC_LEN-1:0][DATA_W-1:0] IN_Y,
    input  logic                           IN_START,
    input  logic                           IN_ABORT,
    output logic                           IN_READY,
    output logic signed [OUT_W-1:0]        OUT_DAT,
    output logic signed [OUT16_W-1:0]      OUT_DAT16,
    output logic                           OUT_XFC
`ifdef DOT_BOX_SAT_FLAG_EN
    ,
    output logic                           OUT_SAT
`endif
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = acc_width(DATA_W, VEC_LEN);
    localparam int IDX_W  = $clog2(VEC_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [VEC_LEN-1:0][DATA_W-1:0] xcap_q, xcap_d;
    logic [VEC_LEN-1:0][DATA_W-1:0] ycap_q, ycap_d;
    logic signed [PROD_W-1:0]       prod_q, prod_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic signed [OUT_W-1:0]        out_dat_q, out_dat_d;
    logic signed [OUT16_W-1:0]      out_dat16_q, out_dat16_d;
    logic                           out_xfc_q, out_xfc_d;
    logic                           ready_q, ready_d;

    logic signed [DATA_W-1:0]       x_sel_s, y_sel_s;
    logic signed [PROD_W-1:0]       x_ext_s, y_ext_s;
    logic signed [ACC_W-1:0]        prod_ext_s;
    logic signed [OUT_W-1:0]        clip_s;
    logic signed [OUT16_W-1:0]      dat16_s;

    assign x_sel_s    = xcap_q[idx_q];
    assign y_sel_s    = ycap_q[idx_q];
    assign x_ext_s    = {{DATA_W{x_sel_s[DATA_W-1]}}, x_sel_s};
    assign y_ext_s    = {{DATA_W{y_sel_s[DATA_W-1]}}, y_sel_s};
    assign prod_ext_s = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};

`ifdef DOT_BOX_SAT_FLAG_EN
    logic sat_full_s, sat16_s;
`endif

    dot_box_sat_round #(
        .ACC_W      (ACC_W),
        .OUT_W      (OUT_W),
        .FRAC_SHIFT (FRAC_SHIFT),
        .OUT16_W    (OUT16_W)
    ) u_sat_round (
        .acc      (acc_q),
        .clip     (clip_s),
        .dat16    (dat16_s)
`ifdef DOT_BOX_SAT_FLAG_EN
        ,
        .sat_full (sat_full_s),
        .sat16    (sat16_s)
`endif
    );

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            xcap_q      <= '0;
            ycap_q      <= '0;
            prod_q      <= '0;
            acc_q       <= '0;
            out_dat_q   <= '0;
            out_dat16_q <= '0;
            out_xfc_q   <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            xcap_q      <= xcap_d;
            ycap_q      <= ycap_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            out_dat_q   <= out_dat_d;
            out_dat16_q <= out_dat16_d;
            out_xfc_q   <= out_xfc_d;
            ready_q     <= ready_d;
        end
    end

    // Next-state logic; abort only acts while a vector is being consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (IN_START) state_d = ST_RUN;
                else          state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (IN_ABORT)               state_d = ST_IDLE;
                else if (idx_q == LAST_IDX) state_d = ST_DRAIN;
                else                        state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (IN_ABORT) state_d = ST_IDLE;
                else          state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture, MAC pipeline and result registers.
    always_comb begin
        xcap_d      = xcap_q;
        ycap_d      = ycap_q;
        idx_d       = idx_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        out_dat_d   = out_dat_q;
        out_dat16_d = out_dat16_q;
        out_xfc_d   = 1'b0;
        ready_d     = (state_d == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (IN_START) begin
                    xcap_d = IN_X;
                    ycap_d = IN_Y;
                    idx_d  = '0;
                    prod_d = '0;
                    acc_d  = '0;
                end else begin
                    idx_d  = idx_q;
                end
            end
            ST_RUN: begin
                prod_d = x_ext_s * y_ext_s;
                acc_d  = acc_q + prod_ext_s;
                if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
                else                   idx_d = idx_q;
            end
            ST_DRAIN: begin
                acc_d = acc_q + prod_ext_s;
            end
            ST_DONE: begin
                out_dat_d   = clip_s;
                out_dat16_d = dat16_s;
                out_xfc_d   = 1'b1;
            end
            default: begin
                out_xfc_d = 1'b0;
            end
        endcase
    end

    assign IN_READY  = ready_q;
    assign OUT_DAT   = out_dat_q;
    assign OUT_DAT16 = out_dat16_q;
    assign OUT_XFC   = out_xfc_q;

`ifdef DOT_BOX_SAT_FLAG_EN
    logic out_sat_q, out_sat_d;

    // Saturation flag follows the same load/hold timing as OUT_DAT.
    always_comb begin
        if (state_q == ST_DONE) out_sat_d = sat_full_s | sat16_s;
        else                    out_sat_d = out_sat_q;
    end

    // Saturation flag register.
    always_ff @(posedge clk) begin
        if (!reset_n) out_sat_q <= 1'b0;
        else          out_sat_q <= out_sat_d;
    end

    assign OUT_SAT = out_sat_q;

`ifndef SYNTHESIS
    // Simulation notice when a result is clamped.
    always_ff @(posedge clk) begin
        if (reset_n && (state_q == ST_DONE) && (sat_full_s || sat16_s)) begin
            $display("dot_box_param: result saturated at %0t", $time);
        end
    end
`endif
`endif

endmodule

// File: doc/dot_box_param.md
Name: dot_box_param

Overview:
- Parametrised next-generation dot-product engine: signed dot product of two VEC_LEN-element vectors of DATA_W-bit samples.
- Computes one multiply-accumulate per cycle through a registered multiplier stage.
- Produces a saturated OUT_W-bit result and a shifted, rounded, saturated OUT16_W-bit result.
- Adds over the current generation: input capture at start, a ready indication, abort, a full-width accumulator with end-of-vector saturation, and a sticky output hold.

Parameters:
- DATA_W, 16, signed sample width of IN_X/IN_Y elements.
- VEC_LEN, 8, elements per vector (>=2).
- OUT_W, 32, width of the saturated full result OUT_DAT.
- FRAC_SHIFT, 16, right-shift applied to form OUT_DAT16 (1..OUT_W-1).
- OUT16_W, 16, width of OUT_DAT16.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous reset, active-low, sampled on the clk rising edge.
- IN_X  in  VEC_LEN x DATA_W signed  vector X.
- IN_Y  in  VEC_LEN x DATA_W signed  vector Y.
- IN_START  in  1  start request; honoured only when IN_READY=1.
- IN_ABORT  in  1  cancel the operation in progress.
- IN_READY  out  1  block idle, able to accept IN_START.
- OUT_DAT  out  OUT_W signed  saturated dot product.
- OUT_DAT16  out  OUT16_W signed  shifted, rounded, saturated result.
- OUT_XFC  out  1  one-cycle done pulse; result valid.

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, index=0, accumulator=0, product register=0. OUT_DAT=0, OUT_DAT16=0, OUT_XFC=0, IN_READY=1. Reset wins over every other input, including mid-run.
- State machine states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - IN_READY=1.
  - On IN_START=1, IN_X and IN_Y are copied into internal registers, the accumulator and index are cleared, and state goes to RUN.
  - Input changes after that edge have no effect on the operation.
- RUN:
  - Each cycle, product register <= xcap[index]*ycap[index] (2*DATA_W bits) and index increments.
  - The accumulator adds the previous cycle's product register (zero on the first RUN cycle).
  - When index = VEC_LEN-1, state goes to DRAIN.
- DRAIN: the accumulator adds the final product; state goes to DONE.
- DONE:
  - OUT_XFC=1 for exactly this one cycle.
  - OUT_DAT and OUT_DAT16 are registered at entry to DONE and hold until the next DONE or reset.
  - State goes to IDLE.
- Latency: IN_START sampled at edge T, OUT_XFC=1 during the cycle after edge T+VEC_LEN+2. Back-to-back throughput is one result per VEC_LEN+3 cycles.
- IN_READY=0 in RUN, DRAIN and DONE. IN_START is ignored outside IDLE and is not queued.
- IN_ABORT=1 in RUN or DRAIN: state goes to IDLE next edge, no OUT_XFC, outputs keep their previous values. IN_ABORT is ignored in IDLE and DONE.
- If IN_ABORT and IN_START are both 1 in IDLE, IN_START is honoured.
- Accumulator width ACC_W = 2*DATA_W + clog2(VEC_LEN); it never overflows internally.
- Full-result saturation: clip = ACC clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Shift and round:
  - s = (clip >>> FRAC_SHIFT) + clip[FRAC_SHIFT-1]. This is round-half-up; computed one bit wider than needed.
  - OUT_DAT16 = s clamped to [-2^(OUT16_W-1), 2^(OUT16_W-1)-1]. Rounding never wraps a positive maximum to negative.

Optional Feature:
- Macro: DOT_BOX_SAT_FLAG_EN.
- When defined:
  - Extra output port OUT_SAT (1 bit), registered at entry to DONE and held like OUT_DAT, reset 0.
  - OUT_SAT=1 if OUT_DAT clamped or OUT_DAT16 clamped in that computation.
  - Simulation-only $display on saturation.
- When undefined: no OUT_SAT port and no saturation detection logic. Results are identical.

Decomposition:
- Package dot_box_pkg holds:
  - The state enum typedef (IDLE/RUN/DRAIN/DONE).
  - A clog2-based ACC_W function.
  - Saturation bound constant functions for a given width.
- One sub-module is natural: dot_box_sat_round. It is purely combinational, takes the ACC_W accumulator, and outputs clip, OUT_DAT16 and the saturation flags.
- The control FSM, capture registers, multiplier and accumulator stay in dot_box_param.

Test Plan:
All scenarios use default parameters.
- All X=1, Y=1, start: OUT_XFC high 10 cycles after the start edge; OUT_DAT=8, OUT_DAT16=0; IN_READY low during the run.
- All X=256, Y=256: OUT_DAT=524288 (0x00080000), OUT_DAT16=8.
- Rounding: X[0]=256, Y[0]=128, all others 0: OUT_DAT=32768 (0x8000), OUT_DAT16=1. X[0]=255, Y[0]=128: OUT_DAT=32640, OUT_DAT16=0.
- Saturation high: all X=Y=-32768: OUT_DAT=0x7FFFFFFF, OUT_DAT16=0x7FFF (no wrap), OUT_SAT=1 if enabled.
- Saturation low: all X=-32768, Y=32767: OUT_DAT=0x80000000, OUT_DAT16=0x8000.
- Control:
  - Complete a run with result 8.
  - Start again, assert IN_ABORT at RUN cycle 3: no OUT_XFC, OUT_DAT stays 8, IN_READY returns to 1.
  - Assert IN_START mid-run: ignored.
  - Drive reset_n=0 mid-run: all outputs 0 next cycle.
